// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI initiator.
//   - command encodings carried in tx_word[9:8]
//   - word/data widths and frame lengths (in SCLK bits)
//   - master state enumeration
//   - helper returning the terminal bit-counter value for a command
package spi_pkg;

  localparam int WORD_W        = 10;
  localparam int DATA_W        = 8;
  localparam int FRAME_BITS_WR = 10;
  localparam int FRAME_BITS_RD = 18;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Last bit index of a frame: read-data frames carry 8 extra reply bits.
  function automatic logic [4:0] frame_last_bit(input logic [1:0] cmd);
    if (cmd == CMD_RD_DATA) begin
      return 5'(FRAME_BITS_RD - 1);
    end else begin
      return 5'(FRAME_BITS_WR - 1);
    end
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period timer for the SPI initiator.
//   clk, rst_n : system clock, async active-low reset
//   en         : count while high; counter is held at zero while low
//   tick       : single-cycle pulse every CLK_DIV enabled cycles
// The count reloads on every tick, so the first tick after enable rises
// arrives exactly CLK_DIV cycles later.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt_r;

  assign tick = en && (cnt_r == 8'(CLK_DIV - 1));

  // Divider count: clears while disabled and on every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (!en || tick) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator for the 10-bit command/data word protocol.
//   clk, rst_n : system clock, async active-low reset
//   start      : frame request, accepted only in IDLE
//   tx_word    : [9:8] command, [7:0] address/data, sent MSB-first
//   busy       : high from the cycle after an accepted start until done
//   done       : one-cycle pulse at frame end
//   rd_data    : reply byte of the last read-data frame
//   rd_valid   : one-cycle pulse with done on read-data frames
//   sclk, SS_n, MOSI, MISO : SPI pins (sclk idles low, SS_n active low)
// Frame: SETUP (CLK_DIV low) -> nbits x (CLK_DIV high, CLK_DIV low) -> GAP
// (SS_n high, CLK_DIV cycles) -> IDLE with done.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORD_W-1:0]   tx_word,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                sclk,
  output logic                SS_n,
  output logic                MOSI,
  input  logic                MISO
);

  state_t              state_r;
  state_t              state_s;
  logic                tick_s;
  logic                last_s;
  logic [WORD_W-1:0]   shift_r;
  logic [DATA_W-1:0]   rx_r;
  logic [4:0]          bit_cnt_r;
  logic [4:0]          last_bit_r;
  logic                rd_frame_r;
  logic                busy_r;
  logic                done_r;
  logic                rd_valid_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                sclk_r;
  logic                ss_n_r;
  logic                mosi_r;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_r != IDLE),
    .tick  (tick_s)
  );

  assign last_s   = (bit_cnt_r == last_bit_r);
  assign busy     = busy_r;
  assign done     = done_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign sclk     = sclk_r;
  assign SS_n     = ss_n_r;
  assign MOSI     = mosi_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; SHIFT ends only after the low half of the last bit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SETUP;
        else       state_s = IDLE;
      end
      SETUP: begin
        if (tick_s) state_s = SHIFT;
        else        state_s = SETUP;
      end
      SHIFT: begin
        if (tick_s && !sclk_r && last_s) state_s = GAP;
        else                             state_s = SHIFT;
      end
      GAP: begin
        if (tick_s) state_s = IDLE;
        else        state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered pin/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= '0;
      rx_r       <= '0;
      bit_cnt_r  <= 5'd0;
      last_bit_r <= 5'd0;
      rd_frame_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      sclk_r     <= 1'b0;
      ss_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // First bit goes straight to MOSI; the rest queue behind it and
            // zeros fill in, which supplies MOSI=0 during the reply bits.
            shift_r    <= {tx_word[WORD_W-2:0], 1'b0};
            mosi_r     <= tx_word[WORD_W-1];
            ss_n_r     <= 1'b0;
            busy_r     <= 1'b1;
            bit_cnt_r  <= 5'd0;
            rx_r       <= '0;
            rd_frame_r <= (tx_word[9:8] == CMD_RD_DATA);
            last_bit_r <= frame_last_bit(tx_word[9:8]);
          end
        end
        SETUP: begin
          if (tick_s) sclk_r <= 1'b1;
        end
        SHIFT: begin
          if (tick_s) begin
            if (sclk_r) begin
              // Falling edge: the only place MOSI moves during a frame.
              sclk_r  <= 1'b0;
              mosi_r  <= shift_r[WORD_W-1];
              shift_r <= {shift_r[WORD_W-2:0], 1'b0};
            end else if (last_s) begin
              ss_n_r <= 1'b1;
            end else begin
              // Rising edge into bit bit_cnt_r+1; reply bits are 10..17.
              sclk_r    <= 1'b1;
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r >= 5'(FRAME_BITS_WR - 1)) begin
                rx_r <= {rx_r[DATA_W-2:0], MISO};
              end
            end
          end
        end
        GAP: begin
          if (tick_s) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            if (rd_frame_r) begin
              rd_data_r  <= rx_r;
              rd_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          ss_n_r <= 1'b1;
          sclk_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start2, start1;
  logic [9:0] tx2, tx1;
  logic       busy2, done2, rdv2, sclk2, ss2, mosi2, miso2;
  logic       busy1, done1, rdv1, sclk1, ss1, mosi1;
  logic [7:0] rdd2, rdd1;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state
  logic [7:0] reply = 8'hA5;
  int         fcnt  = 0;

  // Per-frame measurements
  int          r_ss_low, r_rise, r_done_at, r_done_cnt, r_rdv_at, r_rdv_cnt;
  int          r_mosi_err, r_ss_high, r_ss_fall2;
  logic        r_busy1, r_busy_done;
  logic [17:0] r_bits;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .tx_word(tx2),
    .busy(busy2), .done(done2), .rd_data(rdd2), .rd_valid(rdv2),
    .sclk(sclk2), .SS_n(ss2), .MOSI(mosi2), .MISO(miso2)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tx_word(tx1),
    .busy(busy1), .done(done1), .rd_data(rdd1), .rd_valid(rdv1),
    .sclk(sclk1), .SS_n(ss1), .MOSI(mosi1), .MISO(1'b0)
  );

  // Slave: restart bit count at select.
  always @(negedge ss2) fcnt = 0;

  // Slave: after falling edge f, present reply bit for frame bit f (10..17).
  always @(negedge sclk2) begin
    fcnt = fcnt + 1;
    if (fcnt >= 10 && fcnt <= 17) miso2 = reply[17-fcnt];
    else                          miso2 = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start a frame on dut1 (sel=1) or dut2 and monitor win cycles after accept.
  task automatic run_frame(input bit sel, input logic [9:0] word, input int win,
                           input int inj_k, input bit hold);
    logic ps, pm, s_ss, s_sclk, s_mosi, s_done, s_rdv, s_busy;
    r_ss_low = 0; r_rise = 0; r_done_at = -1; r_done_cnt = 0;
    r_rdv_at = -1; r_rdv_cnt = 0; r_mosi_err = 0; r_ss_high = 0;
    r_ss_fall2 = -1; r_busy1 = 1'b0; r_busy_done = 1'bx; r_bits = '0;
    ps = 1'b0; pm = 1'b0;
    if (sel) begin tx1 = word; start1 = 1'b1; end
    else     begin tx2 = word; start2 = 1'b1; end
    @(posedge clk);
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin start1 = 1'b0; start2 = 1'b0; end
      if (k == inj_k) begin start2 = 1'b1; tx2 = 10'h3FF; end
      if (inj_k > 0 && k == inj_k + 1) begin start2 = 1'b0; tx2 = word; end
      s_ss   = sel ? ss1   : ss2;
      s_sclk = sel ? sclk1 : sclk2;
      s_mosi = sel ? mosi1 : mosi2;
      s_done = sel ? done1 : done2;
      s_rdv  = sel ? rdv1  : rdv2;
      s_busy = sel ? busy1 : busy2;
      if (k == 1) r_busy1 = s_busy;
      if (!s_ss) begin
        r_ss_low++;
        if (r_ss_high > 0 && r_ss_fall2 < 0) r_ss_fall2 = k;
      end else if (r_ss_low > 0 && r_ss_fall2 < 0) begin
        r_ss_high++;
      end
      if (s_sclk && !ps) begin
        r_rise++;
        r_bits = {r_bits[16:0], s_mosi};
      end
      if (s_sclk && (s_mosi !== pm)) r_mosi_err++;
      if (s_done) begin
        r_done_cnt++;
        if (r_done_at < 0) begin r_done_at = k; r_busy_done = s_busy; end
      end
      if (s_rdv) begin
        r_rdv_cnt++;
        if (r_rdv_at < 0) r_rdv_at = k;
      end
      ps = s_sclk;
      pm = s_mosi;
    end
  endtask

  initial begin
    bit seen;
    int dcnt;
    rst_n = 1'b0; start2 = 1'b0; start1 = 1'b0; tx2 = '0; tx1 = '0; miso2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_busy",  {31'd0, busy2}, 32'd0);
    check("rst_done",  {31'd0, done2}, 32'd0);
    check("rst_rdv",   {31'd0, rdv2},  32'd0);
    check("rst_rdd",   {24'd0, rdd2},  32'h00);
    check("rst_sclk",  {31'd0, sclk2}, 32'd0);
    check("rst_ss",    {31'd0, ss2},   32'd1);
    check("rst_mosi",  {31'd0, mosi2}, 32'd0);
    check("rst_ss1",   {31'd0, ss1},   32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write-address frame, CLK_DIV=2
    run_frame(1'b0, 10'h05A, 50, 0, 1'b0);
    check("wr_busy1",    {31'd0, r_busy1}, 32'd1);
    check("wr_ss_low",   r_ss_low,   32'd42);
    check("wr_rise",     r_rise,     32'd10);
    check("wr_bits",     {14'd0, r_bits}, 32'h05A);
    check("wr_done_at",  r_done_at,  32'd45);
    check("wr_done_cnt", r_done_cnt, 32'd1);
    check("wr_busy_done",{31'd0, r_busy_done}, 32'd0);
    check("wr_rdv_cnt",  r_rdv_cnt,  32'd0);
    check("wr_rdd",      {24'd0, rdd2}, 32'h00);
    check("wr_mosi_hi",  r_mosi_err, 32'd0);

    // Read-data frame, slave answers 8'hA5
    reply = 8'hA5;
    run_frame(1'b0, 10'h300, 82, 0, 1'b0);
    check("rd_ss_low",   r_ss_low,   32'd74);
    check("rd_rise",     r_rise,     32'd18);
    check("rd_bits",     {14'd0, r_bits}, 32'h30000);
    check("rd_done_at",  r_done_at,  32'd77);
    check("rd_rdv_at",   r_rdv_at,   32'd77);
    check("rd_rdv_cnt",  r_rdv_cnt,  32'd1);
    check("rd_rdd",      {24'd0, rdd2}, 32'hA5);
    check("rd_mosi_hi",  r_mosi_err, 32'd0);

    // Start re-pulsed mid-frame with another word: ignored
    run_frame(1'b0, 10'h0C3, 60, 10, 1'b0);
    check("ign_ss_low",   r_ss_low,   32'd42);
    check("ign_bits",     {14'd0, r_bits}, 32'h0C3);
    check("ign_done_at",  r_done_at,  32'd45);
    check("ign_done_cnt", r_done_cnt, 32'd1);
    check("ign_rdd_hold", {24'd0, rdd2}, 32'hA5);

    // Reset mid-frame at N+20 (sclk high, MOSI=1 at that point)
    tx2 = 10'h3AB; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk); start2 = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_abort_sclk", {31'd0, sclk2}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ss",   {31'd0, ss2},   32'd1);
    check("abort_sclk", {31'd0, sclk2}, 32'd0);
    check("abort_mosi", {31'd0, mosi2}, 32'd0);
    check("abort_busy", {31'd0, busy2}, 32'd0);
    check("abort_rdd",  {24'd0, rdd2},  32'h00);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done2 || rdv2) dcnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done2 || rdv2) dcnt++;
    end
    check("abort_no_done", dcnt, 32'd0);
    run_frame(1'b0, 10'h05A, 50, 0, 1'b0);
    check("post_ss_low",   r_ss_low,   32'd42);
    check("post_bits",     {14'd0, r_bits}, 32'h05A);
    check("post_done_at",  r_done_at,  32'd45);

    // Back-to-back with start held high
    run_frame(1'b0, 10'h155, 50, 0, 1'b1);
    start2 = 1'b0;
    check("b2b_done_at", r_done_at,  32'd45);
    check("b2b_ss_high", r_ss_high,  32'd3);
    check("b2b_ss_fall", r_ss_fall2, 32'd46);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done2) seen = 1'b1;
    end
    check("b2b_second_done", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);

    // CLK_DIV=1 write-data frame
    run_frame(1'b1, 10'h1FF, 26, 0, 1'b0);
    check("div1_ss_low",  r_ss_low,   32'd21);
    check("div1_rise",    r_rise,     32'd10);
    check("div1_bits",    {14'd0, r_bits}, 32'h1FF);
    check("div1_done_at", r_done_at,  32'd23);
    check("div1_mosi_hi", r_mosi_err, 32'd0);
    check("div1_rdv_cnt", r_rdv_cnt,  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
